// File: rtl/ifetch_queue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ifetch_queue_pkg                                           |
// | Brief   : Shared constants and types for the instruction fetch queue |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ifetch_queue_pkg;

  localparam logic [1:0]  IFQ_IDLE     = 2'd0;
  localparam logic [1:0]  IFQ_WAIT     = 2'd1;
  localparam logic [1:0]  IFQ_DROP     = 2'd2;

  localparam logic [2:0]  KSEG1_REGION = 3'b101;
  localparam logic [31:0] IFQ_RESET_PC = 32'hBFC0_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;

  function automatic logic is_kseg1(input logic [31:0] addr);
    return addr[31:29] == KSEG1_REGION;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_queue_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ifq_fifo_2w2r                                              |
// | Brief   : Circular queue with two write and two read ports           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ifq_fifo_2w2r #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [1:0]               push_n,
  input  logic [1:0]               pop_n,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata_1,
  input  logic [WIDTH-1:0]         wdata_2,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         rdata_1,
  output logic [WIDTH-1:0]         rdata_2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_wr_ptr_1;
  logic [PW-1:0]    w_rd_ptr_1;

  assign w_wr_ptr_1 = r_wr_ptr + PW'(1);
  assign w_rd_ptr_1 = r_rd_ptr + PW'(1);

  // Flush outranks any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(push_n);
      r_rd_ptr <= r_rd_ptr + PW'(pop_n);
      r_count  <= r_count + CW'(push_n) - CW'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && !flush) begin
      if (push_n != 2'd0) r_mem[r_wr_ptr]   <= wdata_1;
      if (push_n == 2'd2) r_mem[w_wr_ptr_1] <= wdata_2;
    end
  end

  assign count   = r_count;
  assign rdata_1 = r_mem[r_rd_ptr];
  assign rdata_2 = r_mem[w_rd_ptr_1];

endmodule
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ifetch_queue                                               |
// | Brief   : Fetch PC generation, ICache request port and fetch buffer  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] RESET_PC = IFQ_RESET_PC
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        redirect_vld,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ic_addr,
  output logic [1:0]  ic_en,
  output logic        ic_cached,
  input  logic        ic_stall,
  input  logic        ic_ready_1,
  input  logic        ic_ready_2,
  input  logic [31:0] ic_rdata_1,
  input  logic [31:0] ic_rdata_2,
  input  logic [1:0]  dec_pop,
  output logic        out_vld_1,
  output logic        out_vld_2,
  output logic [31:0] out_inst_1,
  output logic [31:0] out_inst_2,
  output logic [31:0] out_pc_1,
  output logic [31:0] out_pc_2
);

  localparam int            CW          = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] c_issue_max = CW'(DEPTH - 2);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   w_pc_nxt;
  logic [31:0]   r_pend_pc;
  logic [31:0]   w_pend_pc_nxt;
  logic [1:0]    w_push_n;
  logic [CW-1:0] w_count;
  logic [31:0]   w_redir_pc;
  logic          w_resp;
  ifq_entry_t    w_wr_1;
  ifq_entry_t    w_wr_2;
  ifq_entry_t    w_rd_1;
  ifq_entry_t    w_rd_2;
  logic          w_unused;

  assign w_redir_pc = {redirect_pc[31:2], 2'b00};
  assign w_resp     = ic_ready_1 && (r_state != IFQ_IDLE);
  // Response timing is carried entirely by ic_ready_1; stall is informational.
  assign w_unused   = ^{ic_stall, redirect_pc[1:0]};

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pend_pc_nxt = r_pend_pc;
    w_push_n      = 2'd0;
    case (r_state)
      IFQ_IDLE: begin
        if (redirect_vld)                w_pc_nxt    = w_redir_pc;
        else if (w_count <= c_issue_max) w_state_nxt = IFQ_WAIT;
      end
      IFQ_WAIT: begin
        if (w_resp) begin
          w_state_nxt = IFQ_IDLE;
          if (redirect_vld) begin
            w_pc_nxt = w_redir_pc;
          end else begin
            w_push_n = ic_ready_2 ? 2'd2 : 2'd1;
            w_pc_nxt = r_pc + (ic_ready_2 ? 32'd8 : 32'd4);
          end
        end else if (redirect_vld) begin
          w_pend_pc_nxt = w_redir_pc;
          w_state_nxt   = IFQ_DROP;
        end
      end
      IFQ_DROP: begin
        // The newest redirect always wins over an older pending target.
        if (w_resp) begin
          w_state_nxt = IFQ_IDLE;
          w_pc_nxt    = redirect_vld ? w_redir_pc : r_pend_pc;
        end else if (redirect_vld) begin
          w_pend_pc_nxt = w_redir_pc;
        end
      end
      default: w_state_nxt = IFQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= IFQ_IDLE;
      r_pc      <= RESET_PC;
      r_pend_pc <= RESET_PC;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pend_pc <= w_pend_pc_nxt;
    end
  end

  assign ic_addr   = r_pc;
  assign ic_en     = (r_state == IFQ_IDLE) ? 2'b00 : 2'b01;
  assign ic_cached = !is_kseg1(r_pc);

  assign w_wr_1 = '{pc: r_pc,         inst: ic_rdata_1};
  assign w_wr_2 = '{pc: r_pc + 32'd4, inst: ic_rdata_2};

  ifq_fifo_2w2r #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_n  (w_push_n),
    .pop_n   (dec_pop),
    .flush   (redirect_vld),
    .wdata_1 (w_wr_1),
    .wdata_2 (w_wr_2),
    .count   (w_count),
    .rdata_1 (w_rd_1),
    .rdata_2 (w_rd_2)
  );

  assign out_vld_1  = (w_count != '0);
  assign out_vld_2  = (w_count > CW'(1));
  assign out_inst_1 = w_rd_1.inst;
  assign out_inst_2 = w_rd_2.inst;
  assign out_pc_1   = w_rd_1.pc;
  assign out_pc_2   = w_rd_2.pc;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_ifetch_queue                                            |
// | Brief   : Directed and randomized bench with a queue-based model     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  localparam int          DEPTH  = 8;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        redirect_vld, ic_stall, ic_ready_1, ic_ready_2;
  logic        ic_cached, out_vld_1, out_vld_2;
  logic [31:0] redirect_pc, ic_addr, ic_rdata_1, ic_rdata_2;
  logic [31:0] out_inst_1, out_inst_2, out_pc_1, out_pc_2;
  logic [1:0]  ic_en, dec_pop;
  logic [$clog2(DEPTH):0] dut_count;

  int checks = 0;
  int failures = 0;

  // Reference model: queue contents, fetch pc, outstanding/discard flags.
  ifq_entry_t  mq[$];
  bit          m_busy, m_drop;
  logic [31:0] m_pc, m_pend;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .resetn(resetn), .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .ic_addr(ic_addr), .ic_en(ic_en), .ic_cached(ic_cached), .ic_stall(ic_stall),
    .ic_ready_1(ic_ready_1), .ic_ready_2(ic_ready_2), .ic_rdata_1(ic_rdata_1),
    .ic_rdata_2(ic_rdata_2), .dec_pop(dec_pop), .out_vld_1(out_vld_1), .out_vld_2(out_vld_2),
    .out_inst_1(out_inst_1), .out_inst_2(out_inst_2), .out_pc_1(out_pc_1), .out_pc_2(out_pc_2)
  );

  assign dut_count = dut.w_count;

  task automatic tick();
    int n;
    logic [31:0] rp;
    n = mq.size();
    if (!resetn) begin
      mq.delete();
      m_pc = RST_PC; m_busy = 0; m_drop = 0;
    end else begin
      checks++;
      if (dec_pop == 2'd3 || int'(dec_pop) > n) begin
        failures++;
        $display("FAIL pop_legal dec_pop=%0d count=%0d", dec_pop, n);
      end
      rp = {redirect_pc[31:2], 2'b00};
      if (redirect_vld) begin
        mq.delete();
        if (!m_busy) m_pc = rp;
        else if (ic_ready_1) begin m_busy = 0; m_drop = 0; m_pc = rp; end
        else begin m_drop = 1; m_pend = rp; end
      end else begin
        for (int i = 0; i < int'(dec_pop); i++) void'(mq.pop_front());
        if (m_busy && ic_ready_1) begin
          if (m_drop) m_pc = m_pend;
          else begin
            mq.push_back('{pc: m_pc, inst: ic_rdata_1});
            if (ic_ready_2) begin
              mq.push_back('{pc: m_pc + 32'd4, inst: ic_rdata_2});
              m_pc = m_pc + 32'd8;
            end else m_pc = m_pc + 32'd4;
          end
          m_busy = 0; m_drop = 0;
        end else if (!m_busy && (DEPTH - n) >= 2) m_busy = 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_idle();
    redirect_vld = 0; redirect_pc = 0; ic_stall = 0;
    ic_ready_1 = 0; ic_ready_2 = 0; dec_pop = 0;
    ic_rdata_1 = $urandom; ic_rdata_2 = $urandom;
  endtask

  task automatic wait_issue();
    for (int k = 0; k < 6 && !m_busy; k++) tick();
    checks++;
    if (!m_busy || ic_en !== 2'b01) begin
      failures++;
      $display("FAIL issue_timeout ic_en=%b want=01", ic_en);
    end
  endtask

  task automatic respond(input bit two);
    ic_ready_1 = 1; ic_ready_2 = two; ic_stall = 0;
    ic_rdata_1 = $urandom; ic_rdata_2 = $urandom;
    tick();
    ic_ready_1 = 0; ic_ready_2 = 0;
  endtask

  task automatic test_reset();
    drive_idle(); resetn = 0; tick(); tick(); resetn = 1;
    checks++; if (ic_en !== 2'b00 || ic_addr !== RST_PC) begin failures++;
      $display("FAIL reset_cycle1 ic_en=%b ic_addr=%h want 00/%h", ic_en, ic_addr, RST_PC); end
    checks++; if (out_vld_1 !== 1'b0 || out_vld_2 !== 1'b0 || dut_count !== '0) begin failures++;
      $display("FAIL reset_empty vld=%b%b count=%0d want 00/0", out_vld_1, out_vld_2, dut_count); end
    tick();
    checks++; if (ic_en !== 2'b01 || ic_cached !== 1'b0) begin failures++;
      $display("FAIL reset_cycle2 ic_en=%b cached=%b want 01/0", ic_en, ic_cached); end
    ic_ready_1 = 1; ic_rdata_1 = 32'h3C1D_BFC0; tick(); ic_ready_1 = 0;
    checks++; if (out_vld_1 !== 1'b1 || out_pc_1 !== RST_PC || out_inst_1 !== 32'h3C1D_BFC0) begin failures++;
      $display("FAIL first_word vld=%b pc=%h inst=%h want 1/%h/3c1dbfc0", out_vld_1, out_pc_1, out_inst_1, RST_PC); end
    checks++; if (ic_addr !== 32'hBFC0_0004 || ic_en !== 2'b00) begin failures++;
      $display("FAIL first_next_pc ic_addr=%h ic_en=%b want bfc00004/00", ic_addr, ic_en); end
  endtask

  task automatic test_dual();
    redirect_vld = 1; redirect_pc = 32'h8000_0010; tick(); redirect_vld = 0;
    for (int r = 0; r < 4; r++) begin
      wait_issue(); respond(1);
      checks++; if (int'(dut_count) != 2 * (r + 1) || out_pc_1 !== 32'h8000_0010) begin failures++;
        $display("FAIL dual_count round=%0d count=%0d head=%h want %0d/80000010", r, dut_count, out_pc_1, 2 * (r + 1)); end
      checks++; if (ic_addr !== 32'h8000_0010 + 32'(8 * (r + 1)) || out_pc_2 !== 32'h8000_0014) begin failures++;
        $display("FAIL dual_pc round=%0d ic_addr=%h pc2=%h want %h/80000014", r, ic_addr, out_pc_2, 32'h8000_0010 + 32'(8 * (r + 1))); end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (ic_en !== 2'b00 || int'(dut_count) != 8) begin failures++;
        $display("FAIL full_no_issue ic_en=%b count=%0d want 00/8", ic_en, dut_count); end
    end
  endtask

  task automatic test_full_pop();
    dec_pop = 1; tick(); dec_pop = 0; tick();
    checks++; if (ic_en !== 2'b00 || int'(dut_count) != 7 || out_pc_1 !== 32'h8000_0014) begin failures++;
      $display("FAIL seven_no_issue ic_en=%b count=%0d head=%h want 00/7/80000014", ic_en, dut_count, out_pc_1); end
    dec_pop = 2; tick(); dec_pop = 0;
    checks++; if (int'(dut_count) != 5 || ic_en !== 2'b00) begin failures++;
      $display("FAIL pop_to_five count=%0d ic_en=%b want 5/00", dut_count, ic_en); end
    tick();
    checks++; if (ic_en !== 2'b01 || ic_addr !== 32'h8000_0030 || int'(dut_count) != 5) begin failures++;
      $display("FAIL issue_at_five ic_en=%b ic_addr=%h count=%0d want 01/80000030/5", ic_en, ic_addr, dut_count); end
    dec_pop = 2; respond(1); dec_pop = 0;
    checks++; if (int'(dut_count) != 5 || out_pc_1 !== 32'h8000_0024 || ic_addr !== 32'h8000_0038) begin failures++;
      $display("FAIL push_pop_same count=%0d head=%h ic_addr=%h want 5/80000024/80000038", dut_count, out_pc_1, ic_addr); end
  endtask

  task automatic test_redirect_miss();
    wait_issue();
    for (int c = 1; c <= 20; c++) begin
      ic_stall = 1;
      redirect_vld = (c == 5 || c == 8);
      redirect_pc = (c == 5) ? 32'h8000_1000 : 32'h8000_2000;
      tick(); redirect_vld = 0;
      checks++; if (ic_addr !== 32'h8000_0038 || ic_en !== 2'b01) begin failures++;
        $display("FAIL miss_hold cycle=%0d ic_addr=%h ic_en=%b want 80000038/01", c, ic_addr, ic_en); end
    end
    respond(0);
    checks++; if (int'(dut_count) != 0 || out_vld_1 !== 1'b0 || ic_addr !== 32'h8000_2000 || ic_en !== 2'b00) begin failures++;
      $display("FAIL drop_resp count=%0d vld=%b ic_addr=%h ic_en=%b want 0/0/80002000/00", dut_count, out_vld_1, ic_addr, ic_en); end
  endtask

  task automatic test_redirect_resp();
    wait_issue(); respond(0); wait_issue();
    ic_ready_1 = 1; ic_ready_2 = 1; redirect_vld = 1; redirect_pc = 32'h8000_3004; dec_pop = 1;
    tick(); drive_idle();
    checks++; if (int'(dut_count) != 0 || out_vld_1 !== 1'b0 || ic_addr !== 32'h8000_3004 || ic_en !== 2'b00) begin failures++;
      $display("FAIL redir_resp count=%0d vld=%b ic_addr=%h ic_en=%b want 0/0/80003004/00", dut_count, out_vld_1, ic_addr, ic_en); end
    tick();
    checks++; if (ic_en !== 2'b01 || ic_addr !== 32'h8000_3004) begin failures++;
      $display("FAIL redir_refetch ic_en=%b ic_addr=%h want 01/80003004", ic_en, ic_addr); end
  endtask

  task automatic test_reset_mid();
    respond(1); wait_issue(); respond(1); wait_issue(); respond(0); wait_issue();
    checks++; if (int'(dut_count) != 5) begin failures++;
      $display("FAIL mid_setup count=%0d want 5", dut_count); end
    resetn = 0; tick();
    checks++; if (ic_en !== 2'b00 || dut_count !== '0 || ic_addr !== RST_PC || out_vld_1 !== 1'b0 || out_vld_2 !== 1'b0) begin failures++;
      $display("FAIL reset_mid ic_en=%b count=%0d ic_addr=%h vld=%b%b want 00/0/%h/00", ic_en, dut_count, ic_addr, out_vld_1, out_vld_2, RST_PC); end
    resetn = 1;
  endtask

  task automatic test_wrap();
    redirect_vld = 1; redirect_pc = 32'hFFFF_FFFB; tick(); redirect_vld = 0;
    checks++; if (ic_addr !== 32'hFFFF_FFF8 || ic_cached !== 1'b1) begin failures++;
      $display("FAIL wrap_redirect ic_addr=%h cached=%b want fffffff8/1", ic_addr, ic_cached); end
    wait_issue(); respond(1);
    checks++; if (ic_addr !== 32'h0 || out_pc_1 !== 32'hFFFF_FFF8 || out_pc_2 !== 32'hFFFF_FFFC) begin failures++;
      $display("FAIL wrap_pc ic_addr=%h pc1=%h pc2=%h want 0/fffffff8/fffffffc", ic_addr, out_pc_1, out_pc_2); end
  endtask

  task automatic test_random();
    int n;
    logic [1:0] e_en;
    for (int c = 0; c < 3000; c++) begin
      n = mq.size();
      redirect_vld = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 2))
        0:       redirect_pc = 32'hA000_0000 | ($urandom & 32'h1FFF_FFFF);
        1:       redirect_pc = 32'h8000_0000 | ($urandom & 32'h1FFF_FFFF);
        default: redirect_pc = $urandom;
      endcase
      ic_ready_1 = m_busy && ($urandom_range(0, 2) == 0);
      ic_ready_2 = ic_ready_1 && ($urandom_range(0, 1) == 1);
      ic_stall   = m_busy && !ic_ready_1;
      ic_rdata_1 = $urandom; ic_rdata_2 = $urandom;
      dec_pop    = 2'($urandom_range(0, (n < 2) ? n : 2));
      tick();
      e_en = m_busy ? 2'b01 : 2'b00;
      checks++; if (ic_en !== e_en) begin failures++;
        $display("FAIL rnd_ic_en cyc=%0d got=%b want=%b", c, ic_en, e_en); end
      checks++; if (ic_addr !== m_pc) begin failures++;
        $display("FAIL rnd_ic_addr cyc=%0d got=%h want=%h", c, ic_addr, m_pc); end
      checks++; if (ic_cached !== (m_pc[31:29] != 3'b101)) begin failures++;
        $display("FAIL rnd_cached cyc=%0d got=%b addr=%h", c, ic_cached, m_pc); end
      checks++; if (int'(dut_count) != mq.size() || out_vld_1 !== (mq.size() >= 1) || out_vld_2 !== (mq.size() >= 2)) begin failures++;
        $display("FAIL rnd_count cyc=%0d got=%0d vld=%b%b want=%0d", c, dut_count, out_vld_1, out_vld_2, mq.size()); end
      if (mq.size() >= 1) begin
        checks++; if ({out_pc_1, out_inst_1} !== mq[0]) begin failures++;
          $display("FAIL rnd_head cyc=%0d got=%h_%h want=%h", c, out_pc_1, out_inst_1, mq[0]); end
      end
      if (mq.size() >= 2) begin
        checks++; if ({out_pc_2, out_inst_2} !== mq[1]) begin failures++;
          $display("FAIL rnd_second cyc=%0d got=%h_%h want=%h", c, out_pc_2, out_inst_2, mq[1]); end
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_dual();
    test_full_pop();
    test_redirect_miss();
    test_redirect_resp();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
